// File: rtl/mp_add_seq_pkg.sv
// Shared types and helpers for the byte-serial multi-precision adder.
package mp_add_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int BYTE_W = 8;

   // Vector is passed zero-extended to the 16-byte maximum operand width.
   function automatic logic [BYTE_W-1:0] byte_sel(
      input logic [16*BYTE_W-1:0] v,
      input logic [4:0]           idx
   );
      return v[BYTE_W*idx +: BYTE_W];
   endfunction
endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle for mp_add_seq.
interface mp_add_seq_if #(
   parameter int NBYTES = 4
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   op_a;
   logic [8*NBYTES-1:0]   op_b;
   logic                  sub;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   sum;
   logic                  carry_out;
   logic                  overflow;

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );
endinterface

// File: rtl/mp_add_seq_adder8.sv
// 8-bit ripple-carry adder shared by every byte step of the sequencer.
module adder8 (
   output logic [7:0] s,
   output logic       co,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci
);
   logic c;

   always_comb begin
      s = '0;
      c = ci;
      for (int i = 0; i < 8; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end
endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial add/subtract sequencer, LSB byte first through one adder8.
// Signed overflow output is enabled by defining MP_ADD_SEQ_OVF_EN.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input logic          clk,
   input logic          rst,
   mp_add_seq_if.slave  bus
);
   localparam int IDXW = $clog2(NBYTES) + 1;
   localparam int W    = BYTE_W * NBYTES;

   state_e            state_q;
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic [W-1:0]      sum_q;
   logic              sub_q;
   logic              cy_q;
   logic              co_q;
   logic              vld_q;
   logic [IDXW-1:0]   idx_q;

   logic [7:0]        add_a;
   logic [7:0]        add_b;
   logic [7:0]        add_s;
   logic              add_co;
   logic              last;

   assign add_a = byte_sel(128'(a_q), 5'(idx_q));
   assign add_b = byte_sel(128'(b_q), 5'(idx_q)) ^ {8{sub_q}};
   assign last  = (idx_q == IDXW'(NBYTES - 1));

   adder8 u_add (
      .s  (add_s),
      .co (add_co),
      .a  (add_a),
      .b  (add_b),
      .ci (cy_q)
   );

`ifdef MP_ADD_SEQ_OVF_EN
   logic ovf_q;
   logic ovf_d;
   // Carry into the MSB xor carry out of it, recovered from the top byte.
   assign ovf_d = add_a[7] ^ add_b[7] ^ add_s[7] ^ add_co;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last) begin
         ovf_q <= ovf_d;
      end else if (state_q == DONE && bus.out_ready) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.overflow = ovf_q;
`else
   assign bus.overflow = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         cy_q    <= 1'b0;
         co_q    <= 1'b0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.op_a;
                  b_q     <= bus.op_b;
                  sub_q   <= bus.sub;
                  cy_q    <= bus.sub;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[BYTE_W*idx_q +: BYTE_W] <= add_s;
               cy_q  <= add_co;
               idx_q <= idx_q + 1'b1;
               if (last) begin
                  co_q    <= add_co;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = vld_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = co_q;
endmodule
